udp_tx_framer: RTL and testbench

//  Sits directly downstream of the SDR packet sender in the Ethernet TX path.

---
 rtl/eth_pkg.sv | 17 +
 rtl/udp_hdr_mux.sv | 23 ++
 rtl/udp_tx_framer.sv | 125 ++++++++++++
 tb/tb_udp_tx_framer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX-path constants and the UDP framer state encoding.
package eth_pkg;

    localparam logic [15:0] ETH_MTU         = 16'd1500;
    localparam logic [15:0] IP_HDR_LEN      = 16'd20;
    localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
    localparam logic [15:0] UDP_MAX_PAYLOAD = ETH_MTU - IP_HDR_LEN - UDP_HDR_LEN;

    typedef enum logic [2:0] {
        IDLE,
        IP_REQ,
        HEADER,
        PAYLOAD,
        DRAIN
    } state_t;

endpackage

// File: rtl/udp_hdr_mux.sv
// Combinational selector for the 8 UDP header bytes, MSB of each field first.
module udp_hdr_mux (
    input  logic [2:0]  i_idx,
    input  logic [15:0] i_src,
    input  logic [15:0] i_dst,
    input  logic [15:0] i_len,
    output logic [7:0]  o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            3'd0:    o_byte = i_src[15:8];
            3'd1:    o_byte = i_src[7:0];
            3'd2:    o_byte = i_dst[15:8];
            3'd3:    o_byte = i_dst[7:0];
            3'd4:    o_byte = i_len[15:8];
            3'd5:    o_byte = i_len[7:0];
            default: o_byte = 8'h00;   // checksum unused in IPv4
        endcase
    end

endmodule

// File: rtl/udp_tx_framer.sv
// Grants the packet sender, prepends the UDP header and streams the datagram
// one byte per tx_clock to the IP layer.
module udp_tx_framer
    import eth_pkg::*;
#(
    parameter logic [15:0] SRC_PORT_BASE = 16'd1024,
    parameter logic [15:0] MAX_PAYLOAD   = UDP_MAX_PAYLOAD,
    parameter logic [7:0]  MIN_GAP       = 8'd4
) (
    input  logic        tx_clock,
    input  logic        reset_n,
    input  logic        udp_tx_request,
    input  logic [15:0] udp_tx_length,
    input  logic [7:0]  port_ID,
    input  logic [7:0]  udp_tx_data,
    input  logic [15:0] to_port,
    output logic        udp_tx_enable,
    output logic        udp_tx_active,
    output logic        ip_tx_request,
    output logic [15:0] ip_tx_length,
    input  logic        ip_tx_enable,
    output logic [7:0]  ip_tx_data,
    output logic        ip_tx_valid,
    output logic        length_err
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [15:0] r_ip_len;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_cnt;
    logic [7:0]  r_gap;
    logic        r_udp_tx_enable;
    logic        r_length_err;

    logic        w_accept;
    logic        w_oversize;
    logic        w_hdr_last;
    logic        w_pay_last;
    logic [7:0]  w_hdr_byte;

    assign w_accept   = (r_state == IDLE) && udp_tx_request;
    assign w_oversize = udp_tx_length > MAX_PAYLOAD;
    assign w_hdr_last = (r_cnt[2:0] == 3'd7);
    assign w_pay_last = (r_cnt == r_len - 16'd1);

    udp_hdr_mux u_hdr_mux (
        .i_idx  (r_cnt[2:0]),
        .i_src  (r_src),
        .i_dst  (r_dst),
        .i_len  (r_ip_len),
        .o_byte (w_hdr_byte)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (udp_tx_request) w_next = w_oversize ? DRAIN : IP_REQ;
            IP_REQ:  if (ip_tx_enable) w_next = HEADER;
            HEADER:  if (w_hdr_last) w_next = (r_len != 16'd0) ? PAYLOAD : DRAIN;
            PAYLOAD: if (w_pay_last) w_next = DRAIN;
            // A request still held from the previous datagram must not retrigger.
            DRAIN:   if (!udp_tx_request && (r_gap >= MIN_GAP)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ip_tx_data = 8'h00;
        if (r_state == HEADER) begin
            ip_tx_data = w_hdr_byte;
        end else if (r_state == PAYLOAD) begin
            ip_tx_data = udp_tx_data;
        end
    end

    assign ip_tx_request = (r_state == IP_REQ) || (r_state == HEADER) || (r_state == PAYLOAD);
    assign ip_tx_valid   = (r_state == HEADER) || (r_state == PAYLOAD);
    assign udp_tx_active = (r_state == PAYLOAD);
    assign udp_tx_enable = r_udp_tx_enable;
    assign length_err    = r_length_err;
    assign ip_tx_length  = r_ip_len;

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_len           <= '0;
            r_ip_len        <= '0;
            r_src           <= '0;
            r_dst           <= '0;
            r_cnt           <= '0;
            r_gap           <= '0;
            r_udp_tx_enable <= 1'b0;
            r_length_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Grant lands on the first header cycle, 8 cycles ahead of the first payload byte.
            r_udp_tx_enable <= (r_state == IP_REQ) && ip_tx_enable;
            r_length_err    <= w_accept && w_oversize;

            if (w_accept) begin
                r_len    <= udp_tx_length;
                r_ip_len <= udp_tx_length + UDP_HDR_LEN;
                r_src    <= SRC_PORT_BASE + {8'd0, port_ID};
                r_dst    <= to_port;
            end

            case (r_state)
                HEADER:  r_cnt <= w_hdr_last ? '0 : r_cnt + 16'd1;
                PAYLOAD: r_cnt <= w_pay_last ? '0 : r_cnt + 16'd1;
                default: r_cnt <= '0;
            endcase

            // Gap counts only cycles with the request released.
            if ((r_state == DRAIN) && !udp_tx_request) begin
                if (r_gap < MIN_GAP) r_gap <= r_gap + 8'd1;
            end else begin
                r_gap <= '0;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: sender and IP-layer handshakes driven on the falling edge.
module tb_udp_tx_framer;

    logic        tx_clock = 1'b0;
    logic        reset_n;
    logic        udp_tx_request;
    logic [15:0] udp_tx_length;
    logic [7:0]  port_ID;
    logic [7:0]  udp_tx_data;
    logic [15:0] to_port;
    logic        udp_tx_enable;
    logic        udp_tx_active;
    logic        ip_tx_request;
    logic [15:0] ip_tx_length;
    logic        ip_tx_enable;
    logic [7:0]  ip_tx_data;
    logic        ip_tx_valid;
    logic        length_err;

    logic [15:0] pay_cnt;
    logic [7:0]  pay_seed;
    int          n_pass  = 0;
    int          n_total = 0;
    int          g_cyc   = 0;

    assign udp_tx_data = pay_seed + pay_cnt[7:0];

    always #5 tx_clock = ~tx_clock;
    always @(posedge tx_clock) g_cyc <= g_cyc + 1;

    udp_tx_framer dut (
        .tx_clock       (tx_clock),
        .reset_n        (reset_n),
        .udp_tx_request (udp_tx_request),
        .udp_tx_length  (udp_tx_length),
        .port_ID        (port_ID),
        .udp_tx_data    (udp_tx_data),
        .to_port        (to_port),
        .udp_tx_enable  (udp_tx_enable),
        .udp_tx_active  (udp_tx_active),
        .ip_tx_request  (ip_tx_request),
        .ip_tx_length   (ip_tx_length),
        .ip_tx_enable   (ip_tx_enable),
        .ip_tx_data     (ip_tx_data),
        .ip_tx_valid    (ip_tx_valid),
        .length_err     (length_err)
    );

    // Runs one request through to the request being released for 'low' cycles.
    task automatic send_frame(
        input  logic [15:0] len,
        input  logic [7:0]  pid,
        input  logic [15:0] dport,
        input  int          en_dly,
        input  int          hold,
        input  int          low,
        output logic [63:0] hdr,
        output int          n_act,
        output int          n_val,
        output int          gaps,
        output int          bad,
        output int          grants,
        output int          errs,
        output int          g2a,
        output int          e2v,
        output int          reqs,
        output int          first_vg,
        output int          last_vg,
        output logic [15:0] iplen,
        output bit          tmo
    );
        int cyc, end_cyc, drop_cyc, grant_cyc, first_act, first_v, last_v, budget;
        bit prev_req, done;
        hdr = '0; n_act = 0; n_val = 0; gaps = 0; bad = 0; grants = 0; errs = 0;
        g2a = -1; e2v = -1; reqs = 0; first_vg = -1; last_vg = -1; iplen = '0; tmo = 1'b0;
        end_cyc = -1; drop_cyc = -1; grant_cyc = -1; first_act = -1; first_v = -1; last_v = -1;
        prev_req = 1'b0; done = 1'b0;
        budget = int'(len) + 100;
        if (budget > 2000) budget = 2000;
        pay_cnt = '0;
        @(negedge tx_clock);
        udp_tx_request = 1'b1;
        udp_tx_length  = len;
        port_ID        = pid;
        to_port        = dport;
        ip_tx_enable   = 1'b0;
        for (cyc = 1; !done; cyc++) begin
            @(negedge tx_clock);
            if (cyc > budget) begin
                tmo = 1'b1;
                break;
            end
            ip_tx_enable = 1'b0;
            if (ip_tx_request && !prev_req) reqs++;
            prev_req = ip_tx_request;
            if (ip_tx_request) iplen = ip_tx_length;
            if (udp_tx_enable) begin
                grants++;
                grant_cyc     = cyc;
                udp_tx_length = 16'hFFFF;
                port_ID       = 8'hAA;
                to_port       = 16'h5555;
            end
            if (length_err) errs++;
            if (udp_tx_active) begin
                n_act++;
                if (first_act < 0) first_act = cyc;
                if (ip_tx_data !== (pay_seed + pay_cnt[7:0])) bad++;
                pay_cnt = pay_cnt + 16'd1;
            end
            if (ip_tx_valid) begin
                if (n_val < 8) hdr = {hdr[55:0], ip_tx_data};
                if (first_v < 0) begin
                    first_v  = cyc;
                    first_vg = g_cyc;
                end else if (cyc != last_v + 1) begin
                    gaps++;
                end
                last_v  = cyc;
                last_vg = g_cyc;
                n_val++;
            end
            if (end_cyc < 0 && (errs > 0 || (n_val > 0 && !ip_tx_valid))) end_cyc = cyc;
            if (end_cyc >= 0 && drop_cyc < 0 && cyc >= end_cyc + hold) begin
                udp_tx_request = 1'b0;
                drop_cyc = cyc;
            end
            if (drop_cyc >= 0 && cyc >= drop_cyc + low) done = 1'b1;
            if (cyc == en_dly) ip_tx_enable = 1'b1;
        end
        ip_tx_enable   = 1'b0;
        udp_tx_request = 1'b0;
        if (first_act >= 0 && grant_cyc >= 0) g2a = first_act - grant_cyc;
        if (first_v >= 0) e2v = first_v - en_dly;
    endtask

    task automatic test_reset;
        logic [40:0] outs;
        reset_n = 1'b0;
        udp_tx_request = 1'b0; udp_tx_length = '0; port_ID = '0; to_port = '0;
        ip_tx_enable = 1'b0; pay_cnt = '0; pay_seed = '0;
        repeat (3) @(negedge tx_clock);
        outs = {udp_tx_enable, udp_tx_active, ip_tx_request, ip_tx_length,
                ip_tx_data, ip_tx_valid, length_err, 12'd0};
        n_total++;
        if (outs !== 41'd0) $display("FAIL reset_outputs got=%h want=0", outs);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge tx_clock);
        ip_tx_enable = 1'b1;
        @(negedge tx_clock);
        ip_tx_enable = 1'b0;
        @(negedge tx_clock);
        outs = {udp_tx_enable, ip_tx_request, ip_tx_valid, 38'd0};
        n_total++;
        if (outs !== 41'd0) $display("FAIL stray_ip_enable got=%h want=0", outs);
        else n_pass++;
    endtask

    task automatic test_mic_frame;
        logic [63:0] hdr; logic [15:0] iplen; bit tmo;
        int n_act, n_val, gaps, bad, grants, errs, g2a, e2v, reqs, fvg, lvg;
        pay_seed = 8'h3C;
        send_frame(16'd132, 8'd2, 16'd1025, 3, 2, 6, hdr, n_act, n_val, gaps, bad,
                   grants, errs, g2a, e2v, reqs, fvg, lvg, iplen, tmo);
        n_total++; if (tmo !== 1'b0) $display("FAIL mic_timeout got=%0d want=0", tmo); else n_pass++;
        n_total++; if (hdr !== 64'h0402_0401_008C_0000) $display("FAIL mic_header got=%h want=04020401008c0000", hdr); else n_pass++;
        n_total++; if (iplen !== 16'd140) $display("FAIL mic_ip_length got=%0d want=140", iplen); else n_pass++;
        n_total++; if (n_act !== 132) $display("FAIL mic_active_cycles got=%0d want=132", n_act); else n_pass++;
        n_total++; if (n_val !== 140) $display("FAIL mic_valid_cycles got=%0d want=140", n_val); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL mic_payload_echo got=%0d bad want=0", bad); else n_pass++;
        n_total++; if (grants !== 1) $display("FAIL mic_grants got=%0d want=1", grants); else n_pass++;
        n_total++; if (e2v !== 1) $display("FAIL mic_enable_latency got=%0d want=1", e2v); else n_pass++;
        n_total++; if (g2a !== 8) $display("FAIL mic_grant_to_active got=%0d want=8", g2a); else n_pass++;
        n_total++; if (errs !== 0) $display("FAIL mic_length_err got=%0d want=0", errs); else n_pass++;
    endtask

    task automatic test_ddc_frame;
        logic [63:0] hdr; logic [15:0] iplen; bit tmo;
        int n_act, n_val, gaps, bad, grants, errs, g2a, e2v, reqs, fvg, lvg;
        pay_seed = 8'h81;
        send_frame(16'd1444, 8'd11, 16'h1234, 5, 2, 6, hdr, n_act, n_val, gaps, bad,
                   grants, errs, g2a, e2v, reqs, fvg, lvg, iplen, tmo);
        n_total++; if (tmo !== 1'b0) $display("FAIL ddc_timeout got=%0d want=0", tmo); else n_pass++;
        n_total++; if (hdr !== 64'h040B_1234_05AC_0000) $display("FAIL ddc_header got=%h want=040b123405ac0000", hdr); else n_pass++;
        n_total++; if (iplen !== 16'd1452) $display("FAIL ddc_ip_length got=%0d want=1452", iplen); else n_pass++;
        n_total++; if (g2a !== 8) $display("FAIL ddc_grant_to_active got=%0d want=8", g2a); else n_pass++;
        n_total++; if (n_val !== 1452 || gaps !== 0) $display("FAIL ddc_valid_run got=%0d gaps=%0d want=1452 gaps=0", n_val, gaps); else n_pass++;
        n_total++; if (n_act !== 1444 || bad !== 0) $display("FAIL ddc_payload got=%0d bad=%0d want=1444 bad=0", n_act, bad); else n_pass++;
        n_total++; if (reqs !== 1) $display("FAIL ddc_ip_request_edges got=%0d want=1", reqs); else n_pass++;
    endtask

    task automatic test_oversize;
        logic [63:0] hdr; logic [15:0] iplen; bit tmo;
        int n_act, n_val, gaps, bad, grants, errs, g2a, e2v, reqs, fvg, lvg;
        pay_seed = 8'h00;
        send_frame(16'd1473, 8'd5, 16'd1025, 2, 12, 6, hdr, n_act, n_val, gaps, bad,
                   grants, errs, g2a, e2v, reqs, fvg, lvg, iplen, tmo);
        n_total++; if (tmo !== 1'b0) $display("FAIL over_timeout got=%0d want=0", tmo); else n_pass++;
        n_total++; if (errs !== 1) $display("FAIL over_length_err got=%0d want=1", errs); else n_pass++;
        n_total++; if (grants !== 0) $display("FAIL over_grants got=%0d want=0", grants); else n_pass++;
        n_total++; if (reqs !== 0 || n_val !== 0) $display("FAIL over_no_stream got=%0d/%0d want=0/0", reqs, n_val); else n_pass++;
        pay_seed = 8'h77;
        send_frame(16'd1, 8'd5, 16'd1025, 2, 2, 6, hdr, n_act, n_val, gaps, bad,
                   grants, errs, g2a, e2v, reqs, fvg, lvg, iplen, tmo);
        n_total++; if (hdr !== 64'h0405_0401_0009_0000) $display("FAIL over_recover_header got=%h want=0405040100090000", hdr); else n_pass++;
        n_total++; if (n_act !== 1 || bad !== 0 || tmo !== 1'b0) $display("FAIL over_recover_payload got=%0d bad=%0d want=1 bad=0", n_act, bad); else n_pass++;
    endtask

    task automatic test_zero_length;
        logic [63:0] hdr; logic [15:0] iplen; bit tmo;
        int n_act, n_val, gaps, bad, grants, errs, g2a, e2v, reqs, fvg, lvg;
        send_frame(16'd0, 8'd0, 16'h0050, 1, 2, 6, hdr, n_act, n_val, gaps, bad,
                   grants, errs, g2a, e2v, reqs, fvg, lvg, iplen, tmo);
        n_total++; if (hdr !== 64'h0400_0050_0008_0000) $display("FAIL zero_header got=%h want=0400005000080000", hdr); else n_pass++;
        n_total++; if (n_val !== 8 || tmo !== 1'b0) $display("FAIL zero_valid_cycles got=%0d want=8", n_val); else n_pass++;
        n_total++; if (n_act !== 0) $display("FAIL zero_active got=%0d want=0", n_act); else n_pass++;
        n_total++; if (grants !== 1) $display("FAIL zero_grants got=%0d want=1", grants); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] hdr_a, hdr_b; logic [15:0] ipl_a, ipl_b; bit tmo_a, tmo_b;
        int act_a, val_a, gap_a, bad_a, gr_a, err_a, g2a_a, e2v_a, req_a, fvg_a, lvg_a;
        int act_b, val_b, gap_b, bad_b, gr_b, err_b, g2a_b, e2v_b, req_b, fvg_b, lvg_b;
        pay_seed = 8'h10;
        send_frame(16'd3, 8'd1, 16'd1025, 1, 2, 6, hdr_a, act_a, val_a, gap_a, bad_a,
                   gr_a, err_a, g2a_a, e2v_a, req_a, fvg_a, lvg_a, ipl_a, tmo_a);
        pay_seed = 8'h20;
        send_frame(16'd4, 8'd1, 16'd1025, 1, 2, 6, hdr_b, act_b, val_b, gap_b, bad_b,
                   gr_b, err_b, g2a_b, e2v_b, req_b, fvg_b, lvg_b, ipl_b, tmo_b);
        n_total++; if (val_a !== 11 || req_a !== 1 || gr_a !== 1) $display("FAIL b2b_first got=%0d/%0d/%0d want=11/1/1", val_a, req_a, gr_a); else n_pass++;
        n_total++; if (val_b !== 12 || req_b !== 1 || gr_b !== 1 || tmo_b !== 1'b0) $display("FAIL b2b_second got=%0d/%0d/%0d want=12/1/1", val_b, req_b, gr_b); else n_pass++;
        n_total++; if (hdr_b !== 64'h0401_0401_000C_0000) $display("FAIL b2b_header got=%h want=04010401000c0000", hdr_b); else n_pass++;
        n_total++; if (fvg_b - lvg_a - 1 < 4) $display("FAIL b2b_idle_gap got=%0d want>=4", fvg_b - lvg_a - 1); else n_pass++;
        n_total++; if (bad_a !== 0 || bad_b !== 0) $display("FAIL b2b_payload got=%0d/%0d want=0/0", bad_a, bad_b); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [63:0] hdr; logic [15:0] iplen; bit tmo;
        int n_act, n_val, gaps, bad, grants, errs, g2a, e2v, reqs, fvg, lvg;
        int seen;
        logic [40:0] outs;
        seen = 0;
        pay_seed = 8'h55;
        pay_cnt  = '0;
        @(negedge tx_clock);
        udp_tx_request = 1'b1; udp_tx_length = 16'd100; port_ID = 8'd3; to_port = 16'h0100;
        for (int c = 1; c < 300 && seen < 50; c++) begin
            @(negedge tx_clock);
            ip_tx_enable = (c == 2);
            if (udp_tx_active) begin
                seen++;
                pay_cnt = pay_cnt + 16'd1;
            end
        end
        ip_tx_enable = 1'b0;
        n_total++; if (seen !== 50) $display("FAIL rst_reach_byte50 got=%0d want=50", seen); else n_pass++;
        reset_n = 1'b0;
        #1;
        outs = {udp_tx_enable, udp_tx_active, ip_tx_request, ip_tx_length,
                ip_tx_data, ip_tx_valid, length_err, 12'd0};
        n_total++; if (outs !== 41'd0) $display("FAIL rst_async_outputs got=%h want=0", outs); else n_pass++;
        udp_tx_request = 1'b0;
        repeat (2) @(negedge tx_clock);
        reset_n = 1'b1;
        pay_seed = 8'hE0;
        send_frame(16'd5, 8'd3, 16'h0100, 2, 2, 6, hdr, n_act, n_val, gaps, bad,
                   grants, errs, g2a, e2v, reqs, fvg, lvg, iplen, tmo);
        n_total++; if (hdr !== 64'h0403_0100_000D_0000) $display("FAIL rst_next_header got=%h want=04030100000d0000", hdr); else n_pass++;
        n_total++; if (n_val !== 13 || n_act !== 5 || bad !== 0 || tmo !== 1'b0) $display("FAIL rst_next_frame got=%0d/%0d bad=%0d want=13/5 bad=0", n_val, n_act, bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mic_frame();
        test_ddc_frame();
        test_oversize();
        test_zero_length();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
